// File: rtl/telemetry_rx_pkg.sv
// telemetry_rx_pkg: shared constants and state types for the telemetry receiver
// Holds the packet header bytes, the payload length and the parser/UART state enums.
package telemetry_rx_pkg;
    localparam logic [7:0] HDR_1    = 8'hAA;
    localparam logic [7:0] HDR_2    = 8'h55;
    localparam int         PAY_LEN  = 6;
    localparam logic [2:0] PAY_LAST = 3'(PAY_LEN - 1);
    typedef enum logic [1:0] {HDR1, HDR2, PAYLOAD} pstate_t;
    typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT} ustate_t;
endpackage

// File: rtl/telemetry_rx_uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with input synchronizer
// Ports: clk, rst_n (async active-low), rx_i (raw serial line, idle high),
//        byte_o (received byte, valid with byte_vld_o), byte_vld_o (1-cycle pulse),
//        frm_err_o (1-cycle pulse when the stop bit samples low).
module uart_rx
    import telemetry_rx_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frm_err_o
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    ustate_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          meta_q, sync_q, prev_q;
    logic          vld_q, vld_d, ferr_q, ferr_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end
    // START samples at the half-bit point to reject glitches; every later
    // sample lands one full bit period after the previous one (mid-bit).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            U_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = U_START;
            end
            U_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = sync_q ? U_IDLE : U_DATA;
            end
            U_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {sync_q, sh_q[7:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = U_STOP;
            end
            U_STOP: if (cnt_q == FULL) begin
                cnt_d   = '0;
                vld_d   = sync_q;
                ferr_d  = !sync_q;
                state_d = sync_q ? U_IDLE : U_WAIT;
            end
            U_WAIT: begin
                cnt_d = '0;
                if (sync_q) state_d = U_IDLE;
            end
            default: state_d = U_IDLE;
        endcase
    end
    assign byte_o     = sh_q;
    assign byte_vld_o = vld_q;
    assign frm_err_o  = ferr_q;
endmodule

// File: rtl/telemetry_rx.sv
// telemetry_rx: UART telemetry packet receiver (AA 55 + 3x12-bit readings)
// Ports: clk, rst_n (async active-low), RX (serial line from sensor TX),
//        batt/curr/torque (last valid readings), tlm_vld (update pulse),
//        frm_err (stop-bit error pulse), pkt_err (malformed payload pulse).
module telemetry_rx
    import telemetry_rx_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        tlm_vld,
    output logic        frm_err,
    output logic        pkt_err
);
    logic [7:0]      rx_byte;
    logic            bvld, ferr;
    pstate_t         state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [4:0][7:0] buf_q;
    logic [11:0]     batt_q, curr_q, torque_q;
    logic            tlm_q, tlm_d, pkt_q, pkt_d, frm_q;
    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (RX),
        .byte_o    (rx_byte),
        .byte_vld_o(bvld),
        .frm_err_o (ferr)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HDR1;
            idx_q    <= '0;
            buf_q    <= '0;
            batt_q   <= '0;
            curr_q   <= '0;
            torque_q <= '0;
            tlm_q    <= 1'b0;
            pkt_q    <= 1'b0;
            frm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tlm_q   <= tlm_d;
            pkt_q   <= pkt_d;
            frm_q   <= ferr;
            if (bvld && state_q == PAYLOAD) buf_q <= {buf_q[3:0], rx_byte};
            // Payload bytes 0..4 sit in buf_q[4..0]; the 6th is still on rx_byte.
            if (tlm_d) begin
                batt_q   <= {buf_q[4][3:0], buf_q[3]};
                curr_q   <= {buf_q[2][3:0], buf_q[1]};
                torque_q <= {buf_q[0][3:0], rx_byte};
            end
        end
    end
    // A byte pulse and a framing error never coincide, and all three output
    // pulses are registered from the same cycle, so they are mutually exclusive.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tlm_d   = 1'b0;
        pkt_d   = 1'b0;
        if (ferr) begin
            state_d = HDR1;
        end else if (bvld) begin
            case (state_q)
                HDR1: state_d = rx_byte == HDR_1 ? HDR2 : HDR1;
                HDR2: begin
                    idx_d   = '0;
                    state_d = rx_byte == HDR_2 ? PAYLOAD : rx_byte == HDR_1 ? HDR2 : HDR1;
                end
                PAYLOAD: begin
                    if (!idx_q[0] && rx_byte[7:4] != 4'h0) begin
                        pkt_d   = 1'b1;
                        state_d = HDR1;
                    end else if (idx_q == PAY_LAST) begin
                        tlm_d   = 1'b1;
                        state_d = HDR1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = HDR1;
            endcase
        end
    end
    assign batt    = batt_q;
    assign curr    = curr_q;
    assign torque  = torque_q;
    assign tlm_vld = tlm_q;
    assign pkt_err = pkt_q;
    assign frm_err = frm_q;
endmodule

// File: tb/tb_telemetry_rx.sv
// tb_telemetry_rx: randomized self-checking bench for telemetry_rx against a packet-level model
module tb_telemetry_rx;
    localparam int BD = 16;
    localparam int EV_TLM = 0, EV_PKT = 1, EV_FRM = 2;
    typedef struct {
        int          kind;
        logic [35:0] v;
    } ev_t;
    logic        clk = 1'b0, rst_n = 1'b0, RX = 1'b1;
    logic [11:0] batt, curr, torque;
    logic        tlm_vld, frm_err, pkt_err;
    int          n_run = 0, n_fail = 0;
    ev_t         exp_q[$];
    logic [35:0] cur = '0;
    int          mode = 0;
    logic [7:0]  pl[$];
    telemetry_rx #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .batt(batt), .curr(curr),
        .torque(torque), .tlm_vld(tlm_vld), .frm_err(frm_err), .pkt_err(pkt_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    // Packet-level model: mode 0 hunting for AA, 1 saw AA, 2 collecting payload.
    task automatic model_byte(input logic [7:0] b, input logic stp);
        ev_t e;
        if (!stp) begin
            e.kind = EV_FRM; e.v = '0; exp_q.push_back(e);
            mode = 0; pl.delete();
            return;
        end
        if (mode == 0) begin
            if (b == 8'hAA) mode = 1;
        end else if (mode == 1) begin
            pl.delete();
            mode = b == 8'h55 ? 2 : b == 8'hAA ? 1 : 0;
        end else if (pl.size() % 2 == 0 && b[7:4] != 4'h0) begin
            e.kind = EV_PKT; e.v = '0; exp_q.push_back(e);
            mode = 0;
        end else begin
            pl.push_back(b);
            if (pl.size() == 6) begin
                e.kind = EV_TLM;
                e.v = {pl[0][3:0], pl[1], pl[2][3:0], pl[3], pl[4][3:0], pl[5]};
                exp_q.push_back(e);
                mode = 0;
            end
        end
    endtask
    task automatic send(input logic [7:0] b, input logic stp);
        logic [9:0] f;
        f = {stp, b, 1'b0};
        model_byte(b, stp);
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BD) @(posedge clk);
        end
        RX = 1'b1;
        repeat (4 + $urandom_range(0, 8)) @(posedge clk);
        check("drain", 36'(exp_q.size()), 36'd0);
    endtask
    task automatic send_pkt(input logic [11:0] a, input logic [11:0] c, input logic [11:0] t);
        logic [7:0] p[8];
        p = '{8'hAA, 8'h55, {4'h0, a[11:8]}, a[7:0], {4'h0, c[11:8]}, c[7:0], {4'h0, t[11:8]}, t[7:0]};
        for (int i = 0; i < 8; i++) send(p[i], 1'b1);
    endtask
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; RX = 1'b1;
        cur = '0; mode = 0; pl.delete(); exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outs", {batt, curr, torque}, 36'd0);
            check("reset_pulses", {33'd0, tlm_vld, frm_err, pkt_err}, 36'd0);
        end else begin
            if (int'(tlm_vld) + int'(frm_err) + int'(pkt_err) > 1)
                check("onehot_pulses", {33'd0, tlm_vld, frm_err, pkt_err}, 36'd0);
            if (tlm_vld || frm_err || pkt_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {33'd0, tlm_vld, frm_err, pkt_err}, 36'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {33'd0, tlm_vld, frm_err, pkt_err},
                          e.kind == EV_TLM ? 36'd4 : e.kind == EV_FRM ? 36'd2 : 36'd1);
                    if (e.kind == EV_TLM) cur = e.v;
                end
            end
            check("outputs", {batt, curr, torque}, cur);
        end
    end
    initial begin
        logic [7:0]  p[8];
        logic [11:0] a, c, t;
        int          m, k;
        repeat (3) @(posedge clk);
        #1;
        check("rst_batt", {24'd0, batt}, 36'h000);
        check("rst_tlm", {35'd0, tlm_vld}, 36'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        send_pkt(12'h873, 12'hDEF, 12'hABC);
        check("t31_vals", {batt, curr, torque}, 36'h873DEFABC);
        send(8'h13, 1'b1); send(8'hAA, 1'b1);
        send_pkt(12'h123, 12'h456, 12'h789);
        check("t32_vals", {batt, curr, torque}, 36'h123456789);
        send(8'hAA, 1'b1); send(8'h55, 1'b1); send(8'h18, 1'b1);
        check("t33_hold", {batt, curr, torque}, 36'h123456789);
        send_pkt(12'h0F1, 12'h2E3, 12'h4D5);
        check("t33_next", {batt, curr, torque}, 36'h0F12E34D5);
        p = '{8'hAA, 8'h55, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89};
        for (int i = 0; i < 8; i++) send(p[i], i != 3);
        check("t34_hold", {batt, curr, torque}, 36'h0F12E34D5);
        send_pkt(12'hFFF, 12'h000, 12'h5A5);
        check("t34_next", {batt, curr, torque}, 36'hFFF0005A5);
        @(posedge clk); #1 RX = 1'b0;
        repeat (BD / 4) @(posedge clk);
        #1 RX = 1'b1;
        repeat (4 * BD) @(posedge clk);
        check("t35_hold", {batt, curr, torque}, 36'hFFF0005A5);
        check("t35_drain", 36'(exp_q.size()), 36'd0);
        send(8'hAA, 1'b1); send(8'h55, 1'b1); send(8'h03, 1'b1); send(8'h21, 1'b1);
        do_reset();
        check("t36_zero", {batt, curr, torque}, 36'h0);
        send_pkt(12'h321, 12'h654, 12'h987);
        check("t36_next", {batt, curr, torque}, 36'h321654987);
        for (int n = 0; n < 20; n++) begin
            a = 12'($urandom); c = 12'($urandom); t = 12'($urandom);
            p = '{8'hAA, 8'h55, {4'h0, a[11:8]}, a[7:0], {4'h0, c[11:8]}, c[7:0], {4'h0, t[11:8]}, t[7:0]};
            m = $urandom_range(0, 9);
            k = $urandom_range(0, 7);
            if (m == 6) for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 1'b1);
            if (m == 7) p[2 + 2 * (k % 3)][7:4] = 4'($urandom_range(1, 15));
            for (int i = 0; i < 8; i++) send(m == 9 ? 8'($urandom) : p[i], !(m == 8 && i == k));
        end
        check("final_drain", 36'(exp_q.size()), 36'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
